// File: rtl/split_bits.sv
// ---------------------------------------------------------------------------
// split_bits
//
// Bit-stream splitter. 32-bit packed words are appended to a 64-bit
// left-aligned shift buffer. A consumer peeks at the next 24 bits and
// consumes 0..24 bits per cycle. A word flagged as the last of an image
// closes intake until the buffer fully drains. The drain is marked by a
// one-cycle end-of-image pulse, after which intake reopens for the next
// image. Over-consuming sets a sticky error flag that only reset clears.
//
// Ports
//   clk        in   1   clock, rising edge
//   nrst       in   1   synchronous active-low reset
//   in_bin     in  32   packed stream word, bit 31 first in stream order
//   in_valid   in   1   in_bin valid this cycle
//   in_last    in   1   final word of an image (sampled on accept only)
//   in_ready   out  1   block accepts in_bin this cycle (combinational)
//   out_bin    out 24   peek window, bit 23 is the next unconsumed bit
//   out_len    out  7   number of valid bits in the buffer, 0..64
//   out_valid  out  1   window full, or final word seen and bits remain
//   rd_en      in   1   consume request
//   rd_len     in   5   bits to consume, 0..24
//   out_eoi    out  1   one-cycle pulse when an image has fully drained
//   out_err    out  1   sticky over-consume flag
// ---------------------------------------------------------------------------
module split_bits (
  input  logic        clk,
  input  logic        nrst,
  input  logic [31:0] in_bin,
  input  logic        in_valid,
  input  logic        in_last,
  output logic        in_ready,
  output logic [23:0] out_bin,
  output logic [6:0]  out_len,
  output logic        out_valid,
  input  logic        rd_en,
  input  logic [4:0]  rd_len,
  output logic        out_eoi,
  output logic        out_err
);

  localparam int DATA_W = 32;
  localparam int BUF_W  = 64;
  localparam int WIN_W  = 24;
  localparam int LEN_W  = 7;

  // Places a word directly below the 'fill' bits already held in the
  // left-aligned buffer.
  function automatic logic [BUF_W-1:0] f_place_word(
    input logic [DATA_W-1:0] word,
    input logic [LEN_W-1:0]  fill
  );
    logic [BUF_W-1:0] aligned;
    aligned = {word, {(BUF_W-DATA_W){1'b0}}};
    return aligned >> fill;
  endfunction

  // Registered state
  logic [BUF_W-1:0] r_buff_bin;
  logic [LEN_W-1:0] r_buff_len;
  logic             r_last_seen;
  logic             r_err;
  logic             r_eoi;

  // Next-state terms
  logic [LEN_W-1:0] w_rd_len;
  logic             w_rd_req;
  logic             w_rd_ok;
  logic             w_over;
  logic             w_accept;
  logic [LEN_W-1:0] w_k;
  logic [LEN_W-1:0] w_len_rem;
  logic [LEN_W-1:0] w_len_nxt;
  logic [BUF_W-1:0] w_bin_nxt;
  logic             w_eoi_nxt;

  assign in_ready = (r_buff_len <= LEN_W'(DATA_W)) && !r_last_seen && !r_err;
  assign w_accept = in_valid && in_ready;

  // Once the error flag is set the consume port is dead until reset.
  assign w_rd_len = {2'b00, rd_len};
  assign w_rd_req = rd_en && !r_err;
  assign w_rd_ok  = w_rd_req && (w_rd_len <= r_buff_len);
  assign w_over   = w_rd_req && (w_rd_len >  r_buff_len);
  assign w_k      = w_rd_ok ? w_rd_len : '0;

  // Consume first, then append behind whatever remains.
  assign w_len_rem = r_buff_len - w_k;
  assign w_len_nxt = w_len_rem + (w_accept ? LEN_W'(DATA_W) : '0);
  assign w_bin_nxt = (r_buff_bin << w_k) |
                     (w_accept ? f_place_word(in_bin, w_len_rem) : '0);

  // An accept always adds 32 bits, so an empty result can only come from
  // a consume draining the final image.
  assign w_eoi_nxt = r_last_seen && (w_len_nxt == '0);

  always_ff @(posedge clk) begin
    if (!nrst) begin
      r_buff_bin  <= '0;
      r_buff_len  <= '0;
      r_last_seen <= 1'b0;
      r_err       <= 1'b0;
      r_eoi       <= 1'b0;
    end else begin
      r_buff_bin <= w_bin_nxt;
      r_buff_len <= w_len_nxt;
      r_err      <= r_err | w_over;
      r_eoi      <= w_eoi_nxt;
      if (w_eoi_nxt) begin
        r_last_seen <= 1'b0;
      end else if (w_accept && in_last) begin
        r_last_seen <= 1'b1;
      end
    end
  end

  assign out_bin   = r_buff_bin[BUF_W-1 -: WIN_W];
  assign out_len   = r_buff_len;
  assign out_valid = (r_buff_len >= LEN_W'(WIN_W)) ||
                     (r_last_seen && (r_buff_len != '0));
  assign out_eoi   = r_eoi;
  assign out_err   = r_err;

endmodule

// File: tb/tb_split_bits.sv
module tb_split_bits;

  logic        clk = 1'b0;
  logic        nrst;
  logic [31:0] in_bin;
  logic        in_valid;
  logic        in_last;
  logic        in_ready;
  logic [23:0] out_bin;
  logic [6:0]  out_len;
  logic        out_valid;
  logic        rd_en;
  logic [4:0]  rd_len;
  logic        out_eoi;
  logic        out_err;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model: the buffer is a plain queue of bits in stream order.
  bit mq[$];
  bit m_last;
  bit m_err;
  bit m_eoi;

  always #5 clk = ~clk;

  split_bits dut (
    .clk      (clk),
    .nrst     (nrst),
    .in_bin   (in_bin),
    .in_valid (in_valid),
    .in_last  (in_last),
    .in_ready (in_ready),
    .out_bin  (out_bin),
    .out_len  (out_len),
    .out_valid(out_valid),
    .rd_en    (rd_en),
    .rd_len   (rd_len),
    .out_eoi  (out_eoi),
    .out_err  (out_err)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic bit m_ready();
    return (mq.size() <= 32) && !m_last && !m_err;
  endfunction

  function automatic logic [23:0] m_window();
    logic [23:0] r;
    r = '0;
    for (int i = 0; i < 24; i++)
      if (i < mq.size()) r[23-i] = mq[i];
    return r;
  endfunction

  task automatic m_update(input bit v, input logic [31:0] w, input bit lst,
                          input bit rd, input int rl, input bit rs);
    bit acc;
    bit was_last;
    if (!rs) begin
      mq.delete();
      m_last = 0;
      m_err  = 0;
      m_eoi  = 0;
    end else begin
      acc      = v && m_ready();
      was_last = m_last;
      if (rd && !m_err) begin
        if (rl <= mq.size()) begin
          for (int i = 0; i < rl; i++) void'(mq.pop_front());
        end else begin
          m_err = 1;
        end
      end
      if (acc) begin
        for (int i = 31; i >= 0; i--) mq.push_back(w[i]);
        if (lst) m_last = 1;
      end
      m_eoi = was_last && (mq.size() == 0);
      if (m_eoi) m_last = 0;
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".bin"},   64'(out_bin),   64'(m_window()));
    chk({tag, ".len"},   64'(out_len),   64'(mq.size()));
    chk({tag, ".valid"}, 64'(out_valid), 64'((mq.size() >= 24) || (m_last && mq.size() > 0)));
    chk({tag, ".eoi"},   64'(out_eoi),   64'(m_eoi));
    chk({tag, ".err"},   64'(out_err),   64'(m_err));
  endtask

  // One clock cycle: drive, check combinational ready, clock, check outputs.
  task automatic step(input string tag, input bit v, input logic [31:0] w, input bit lst,
                      input bit rd, input int rl, input bit rs);
    in_valid = v;
    in_bin   = w;
    in_last  = lst;
    rd_en    = rd;
    rd_len   = 5'(rl);
    nrst     = rs;
    #1;
    chk({tag, ".ready"}, 64'(in_ready), 64'(m_ready()));
    @(posedge clk);
    m_update(v, w, lst, rd, rl, rs);
    #1;
    check_model(tag);
  endtask

  initial begin
    bit   v, lst, rd, rs;
    int   rl;
    logic [31:0] w;

    nrst = 0; in_valid = 0; in_bin = '0; in_last = 0; rd_en = 0; rd_len = '0;
    @(posedge clk); #1;

    // Reset state
    step("rst", 1, 32'hFFFF_FFFF, 0, 1, 5, 0);
    chk("rst.ready_c", 64'(in_ready), 64'd1);
    chk("rst.bin_c",   64'(out_bin),  64'd0);
    chk("rst.len_c",   64'(out_len),  64'd0);

    // Accept then consume 4
    step("a32", 1, 32'hDEAD_BEEF, 0, 0, 0, 1);
    chk("a32.bin_c",   64'(out_bin),   64'hDEADBE);
    chk("a32.len_c",   64'(out_len),   64'd32);
    chk("a32.valid_c", 64'(out_valid), 64'd1);
    step("c4", 0, '0, 0, 1, 4, 1);
    chk("c4.bin_c", 64'(out_bin), 64'hEADBEE);
    chk("c4.len_c", 64'(out_len), 64'd28);

    // Append and consume in the same cycle
    step("a33", 1, 32'h1234_5678, 0, 1, 20, 1);
    chk("a33.len_c", 64'(out_len), 64'd40);
    chk("a33.bin_c", 64'(out_bin), 64'hEF1234);

    // Back-pressure at 40 bits
    step("bp0", 1, 32'hCAFE_BABE, 0, 0, 0, 1);
    chk("bp0.len_c", 64'(out_len), 64'd40);
    step("bp1", 1, 32'hCAFE_BABE, 0, 1, 8, 1);
    chk("bp1.ready_c", 64'(in_ready), 64'd1);
    step("bp2", 1, 32'hCAFE_BABE, 0, 0, 0, 1);
    chk("bp2.len_c", 64'(out_len), 64'd64);
    chk("bp2.bin_c", 64'(out_bin), 64'h123456);
    step("dr0", 0, '0, 0, 1, 24, 1);
    step("dr1", 0, '0, 0, 1, 24, 1);
    step("dr2", 0, '0, 0, 1, 16, 1);
    chk("dr2.len_c", 64'(out_len), 64'd0);

    // Over-consume
    step("e0", 1, 32'h0F0F_0F0F, 0, 0, 0, 1);
    step("e1", 0, '0, 0, 1, 24, 1);
    step("e2", 0, '0, 0, 1, 2, 1);
    step("e3", 0, '0, 0, 1, 10, 1);
    chk("e3.err_c", 64'(out_err), 64'd1);
    chk("e3.len_c", 64'(out_len), 64'd6);
    step("e4", 1, 32'h1111_1111, 0, 1, 4, 1);
    chk("e4.len_c",   64'(out_len),  64'd6);
    chk("e4.ready_c", 64'(in_ready), 64'd0);
    step("e5", 0, '0, 0, 0, 0, 0);
    chk("e5.err_c", 64'(out_err), 64'd0);

    // Final word and drain
    step("l0", 1, 32'hA5FF_FFFF, 1, 0, 0, 1);
    chk("l0.len_c",   64'(out_len),   64'd32);
    chk("l0.valid_c", 64'(out_valid), 64'd1);
    step("l1", 0, '0, 0, 1, 24, 1);
    chk("l1.eoi_c",   64'(out_eoi),   64'd0);
    chk("l1.valid_c", 64'(out_valid), 64'd1);
    chk("l1.bin_c",   64'(out_bin),   64'hFF0000);
    step("l2", 0, '0, 0, 1, 8, 1);
    chk("l2.eoi_c",   64'(out_eoi),  64'd1);
    chk("l2.ready_c", 64'(in_ready), 64'd1);
    step("l3", 0, '0, 0, 0, 0, 1);
    chk("l3.eoi_c", 64'(out_eoi), 64'd0);

    // Reset mid-image
    step("m0", 1, 32'h1111_1111, 0, 0, 0, 1);
    step("m1", 1, 32'h2222_2222, 1, 1, 14, 1);
    chk("m1.len_c", 64'(out_len), 64'd50);
    step("m2", 0, '0, 0, 0, 0, 0);
    chk("m2.len_c",   64'(out_len),  64'd0);
    chk("m2.bin_c",   64'(out_bin),  64'd0);
    chk("m2.ready_c", 64'(in_ready), 64'd1);
    chk("m2.eoi_c",   64'(out_eoi),  64'd0);

    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      v   = ($urandom_range(0, 3) != 0);
      w   = $urandom;
      lst = ($urandom_range(0, 15) == 0);
      rd  = ($urandom_range(0, 2) != 0);
      rl  = $urandom_range(0, 24);
      if ($urandom_range(0, 31) != 0 && rl > mq.size()) rl = mq.size();
      rs  = ($urandom_range(0, 199) != 0);
      if (m_err && $urandom_range(0, 7) == 0) rs = 0;
      step("rnd", v, w, lst, rd, rl, rs);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
